mux_feed_sequencer: RTL and testbench
=====================================

# mux_feed_sequencer

Serial-to-parallel front end feeding the 4:1 select mux. Collects 1-bit samples into a WIDTH-bit word and presents it on `datain` with a valid/ack handshake. Drives the mux select `s` from a registered word counter, so `s` is always a known 0/1 and never X or Z after reset.

## Interface
- `WIDTH`, 4: word width and the number of samples per word. Legal range is 2..16.
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  synchronous reset, active-high
- `din`  in  1  serial sample, LSB of the word first
- `din_valid`  in  1  `din` is valid this cycle
- `din_ready`  out  1  block can accept a sample this cycle
- `flush`  in  1  discard the partial word and any presented word
- `datain`  out  WIDTH  assembled word presented to the mux
- `s`  out  1  mux select; toggles once per completed word
- `word_valid`  out  1  `datain` holds a new, unacknowledged word
- `word_ack`  in  1  consumer has taken `datain`
- `word_cnt`  out  8  count of completed words, modulo 256

## Operation
- FSM states are IDLE, FILL and PRESENT. Reset state is IDLE.
- Accept: a sample is taken when `din_valid && din_ready` at a rising edge.
- `din_ready = (state != PRESENT)`. It is combinational from state.
- IDLE:
  - On accept, store `din` in `shreg[0]`, set `bitcnt` to 1, and go to FILL.
  - With no accept, stay in IDLE.
- FILL, normal accept: store `din` in `shreg[bitcnt]` and increment `bitcnt`.
- FILL, WIDTH-th accept (`bitcnt == WIDTH-1`):
  - Load `datain` with the full word: the new bit goes in the MSB, the rest comes from `shreg`.
  - Set `word_valid=1` and toggle `s`.
  - Increment `word_cnt`; it wraps 255→0.
  - Clear `bitcnt` and go to PRESENT.
- PRESENT: hold `datain`, `s` and `word_cnt`.
  - On `word_ack=1`, clear `word_valid` and go to IDLE.
  - Samples offered here are not accepted, because `din_ready=0`.
- `flush` has top priority in every state:
  - Next state is IDLE, `bitcnt` is 0, `shreg` is cleared and `word_valid` is 0.
  - `datain`, `s` and `word_cnt` keep their values.
  - A sample offered in the same cycle is dropped.
- `rst` has priority over `flush`.
- `datain` changes only on word completion or reset; no partial word is ever visible on it.
- `word_ack` while `word_valid=0` is ignored.

## Timing
- Reset values on the edge where `rst=1`:
  - `datain=0`, `s=0`, `word_valid=0`, `word_cnt=0`
  - state IDLE, so `din_ready=1`
  - `bitcnt=0`, `shreg=0`
- Reset mid-word or mid-PRESENT discards everything. There is no residual state.
- Latency: on the edge that accepts the WIDTH-th sample, `datain`, `s`, `word_cnt` and `word_valid` all update together. They are visible in the following cycle.
- Minimum word period is WIDTH+1 cycles: WIDTH accepts plus one PRESENT cycle with `word_ack` held high.
- `din_ready` rises the cycle after `word_ack` is sampled. The earliest next accept is that cycle.
- Gaps in `din_valid` during FILL are allowed. `bitcnt` holds across them and there is no timeout.
- All outputs come from registers except `din_ready`, which is decoded from the state register only.

## Test plan
1. **Reset.** With WIDTH=4, assert `rst` for 2 cycles.
   - Expect `datain=4'h0`, `s=0`, `word_valid=0`, `word_cnt=0`, `din_ready=1`.
   - `s` is never X or Z from the first post-reset cycle.
2. **Single word.** Feed `din` = 1,0,1,1 on 4 consecutive cycles, then ack.
   - After the 4th edge: `datain=4'b1101`, `word_valid=1`, `s=1`, `word_cnt=1`, `din_ready=0`.
   - After ack, the next cycle has `word_valid=0` and `din_ready=1`.
3. **Back-pressure.**
   - Hold `word_ack=0` for 5 cycles with `din_valid=1`: `datain` stays stable, no sample is accepted, and `word_valid` stays 1.
   - Then ack and send 0,0,0,1: `datain=4'b1000`, `s=0`, `word_cnt=2`.
4. **Flush in FILL.** Send 3 samples (1,1,1), then pulse `flush` together with `din_valid=1`.
   - The flush-cycle sample is dropped.
   - Sending 0,1,0,0 then gives `datain=4'b0010`, not a mix with the old bits.
   - `word_cnt` increments by exactly 1.
5. **Flush in PRESENT.** Complete a word, then pulse `flush` without ack.
   - `word_valid` goes to 0 and `din_ready` goes to 1.
   - `datain`, `s` and `word_cnt` are unchanged.
6. **Counter wrap and gaps.** Stream 256 words with random `din_valid` gaps and immediate acks.
   - `word_cnt` wraps 255→0 and `s` ends at 0.
   - A reference model matches every presented word.

Source files
------------

// File: rtl/mux_feed_sequencer.sv
// mux_feed_sequencer: collects LSB-first serial samples into a WIDTH-bit word,
// presents it on datain with a valid/ack handshake and toggles the mux select
// s once per completed word.
//
// Handshakes:
//   - A sample is taken on a rising edge where din_valid && din_ready.
//   - A presented word is taken on a rising edge where word_valid && word_ack.
//   - word_ack while word_valid=0 has no effect.
module mux_feed_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] datain,
  output logic             s,
  output logic             word_valid,
  input  logic             word_ack,
  output logic [7:0]       word_cnt,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    PRESENT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] datain_q, datain_d;
  logic             s_q, s_d;
  logic             word_valid_q, word_valid_d;
  logic [7:0]       word_cnt_q, word_cnt_d;
  logic             accept;

  // Ready depends only on the state register so it never loops back to din_valid.
  assign din_ready  = (state_q != PRESENT);
  assign accept     = din_valid && din_ready;
  assign datain     = datain_q;
  assign s          = s_q;
  assign word_valid = word_valid_q;
  assign word_cnt   = word_cnt_q;
  assign state_dbg  = state_q;

  // Next-state and datapath update; everything holds unless a case changes it.
  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shreg_d      = shreg_q;
    datain_d     = datain_q;
    s_d          = s_q;
    word_valid_d = word_valid_q;
    word_cnt_d   = word_cnt_q;

    if (flush) begin
      // Flush drops the partial word and any presented word, but keeps the
      // last completed word, select and count so the mux side stays stable.
      state_d      = IDLE;
      bitcnt_d     = '0;
      shreg_d      = '0;
      word_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shreg_d    = '0;
            shreg_d[0] = din;
            bitcnt_d   = CW'(1);
            state_d    = FILL;
          end
        end
        FILL: begin
          if (accept) begin
            if (bitcnt_q == CW'(WIDTH - 1)) begin
              // Final sample goes straight into the MSB of the presented word.
              datain_d     = {din, shreg_q[WIDTH-2:0]};
              word_valid_d = 1'b1;
              s_d          = ~s_q;
              word_cnt_d   = word_cnt_q + 8'd1;
              bitcnt_d     = '0;
              shreg_d      = '0;
              state_d      = PRESENT;
            end else begin
              shreg_d[bitcnt_q] = din;
              bitcnt_d          = bitcnt_q + CW'(1);
            end
          end
        end
        PRESENT: begin
          if (word_ack) begin
            word_valid_d = 1'b0;
            state_d      = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State register with synchronous reset taking priority over flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bitcnt_q     <= '0;
      shreg_q      <= '0;
      datain_q     <= '0;
      s_q          <= 1'b0;
      word_valid_q <= 1'b0;
      word_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shreg_q      <= shreg_d;
      datain_q     <= datain_d;
      s_q          <= s_d;
      word_valid_q <= word_valid_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_mux_feed_sequencer.sv
// Directed bench for mux_feed_sequencer with WIDTH=4.
module tb_mux_feed_sequencer;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         din;
  logic         din_valid;
  logic         din_ready;
  logic         flush;
  logic [W-1:0] datain;
  logic         s;
  logic         word_valid;
  logic         word_ack;
  logic [7:0]   word_cnt;
  logic [1:0]   state_dbg;

  int total;
  int bad;

  logic [W-1:0] exp_q[$];
  logic [7:0]   exp_cnt;
  logic         exp_s;

  mux_feed_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .flush      (flush),
    .datain     (datain),
    .s          (s),
    .word_valid (word_valid),
    .word_ack   (word_ack),
    .word_cnt   (word_cnt),
    .state_dbg  (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one word LSB first; optional random idle gaps between samples.
  task automatic send_word(input logic [W-1:0] w, input bit gaps);
    for (int i = 0; i < W; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          din_valid = 1'b0;
          din       = $urandom_range(0, 1);
          step();
        end
      end
      din_valid = 1'b1;
      din       = w[i];
      step();
    end
    din_valid = 1'b0;
  endtask

  task automatic ack_word();
    word_ack = 1'b1;
    step();
    word_ack = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    din       = 1'b0;
    din_valid = 1'b0;
    flush     = 1'b0;
    word_ack  = 1'b0;

    // 1. Reset
    step();
    step();
    rst = 1'b0;
    chk("rst_datain", 32'(datain), 32'h0);
    chk("rst_s", 32'(s), 32'h0);
    chk("rst_wv", 32'(word_valid), 32'h0);
    chk("rst_cnt", 32'(word_cnt), 32'h0);
    chk("rst_ready", 32'(din_ready), 32'h1);

    // 2. Single word 1,0,1,1 -> 4'b1101
    send_word(4'b1101, 1'b0);
    chk("w1_datain", 32'(datain), 32'hD);
    chk("w1_wv", 32'(word_valid), 32'h1);
    chk("w1_s", 32'(s), 32'h1);
    chk("w1_cnt", 32'(word_cnt), 32'h1);
    chk("w1_ready", 32'(din_ready), 32'h0);

    // 3. Back-pressure: samples offered in PRESENT are refused
    din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = i[0];
      step();
      chk("bp_datain", 32'(datain), 32'hD);
      chk("bp_wv", 32'(word_valid), 32'h1);
      chk("bp_ready", 32'(din_ready), 32'h0);
    end
    din_valid = 1'b0;
    ack_word();
    chk("ack_wv", 32'(word_valid), 32'h0);
    chk("ack_ready", 32'(din_ready), 32'h1);
    send_word(4'b1000, 1'b0);
    chk("w2_datain", 32'(datain), 32'h8);
    chk("w2_s", 32'(s), 32'h0);
    chk("w2_cnt", 32'(word_cnt), 32'h2);
    ack_word();

    // Ack with nothing presented is ignored
    ack_word();
    chk("stray_ack_wv", 32'(word_valid), 32'h0);
    chk("stray_ack_ready", 32'(din_ready), 32'h1);
    chk("stray_ack_cnt", 32'(word_cnt), 32'h2);

    // 4. Flush in FILL, with a sample offered in the same cycle
    for (int i = 0; i < 3; i++) begin
      din_valid = 1'b1;
      din       = 1'b1;
      step();
    end
    flush = 1'b1;
    din   = 1'b1;
    step();
    flush     = 1'b0;
    din_valid = 1'b0;
    chk("ffill_ready", 32'(din_ready), 32'h1);
    chk("ffill_wv", 32'(word_valid), 32'h0);
    chk("ffill_datain", 32'(datain), 32'h8);
    chk("ffill_cnt", 32'(word_cnt), 32'h2);
    send_word(4'b0010, 1'b0);
    chk("w3_datain", 32'(datain), 32'h2);
    chk("w3_cnt", 32'(word_cnt), 32'h3);
    chk("w3_s", 32'(s), 32'h1);
    ack_word();

    // 5. Flush in PRESENT
    send_word(4'b1010, 1'b0);
    chk("w4_wv", 32'(word_valid), 32'h1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fpres_wv", 32'(word_valid), 32'h0);
    chk("fpres_ready", 32'(din_ready), 32'h1);
    chk("fpres_datain", 32'(datain), 32'hA);
    chk("fpres_s", 32'(s), 32'h0);
    chk("fpres_cnt", 32'(word_cnt), 32'h4);

    // 6. 256 words with gaps; count wraps through 255 -> 0 and back to 4
    exp_cnt = 8'd4;
    exp_s   = 1'b0;
    for (int n = 0; n < 256; n++) begin
      logic [W-1:0] w;
      logic [W-1:0] e;
      w = W'($urandom_range(0, 15));
      exp_q.push_back(w);
      send_word(w, 1'b1);
      exp_cnt = exp_cnt + 8'd1;
      exp_s   = ~exp_s;
      e = exp_q.pop_front();
      chk("str_datain", 32'(datain), 32'(e));
      chk("str_wv", 32'(word_valid), 32'h1);
      chk("str_cnt", 32'(word_cnt), 32'(exp_cnt));
      chk("str_s", 32'(s), 32'(exp_s));
      ack_word();
    end
    chk("str_end_cnt", 32'(word_cnt), 32'h4);
    chk("str_end_s", 32'(s), 32'h0);

    // Reset mid-word leaves no residue
    send_word(4'b1111, 1'b0);
    ack_word();
    din_valid = 1'b1;
    din       = 1'b1;
    step();
    step();
    rst = 1'b1;
    din_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("mrst_datain", 32'(datain), 32'h0);
    chk("mrst_cnt", 32'(word_cnt), 32'h0);
    chk("mrst_s", 32'(s), 32'h0);
    send_word(4'b0100, 1'b0);
    chk("mrst_w_datain", 32'(datain), 32'h4);
    chk("mrst_w_cnt", 32'(word_cnt), 32'h1);
    ack_word();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
